cmd_frame_builder: RTL and testbench

CMD_FRAME_BUILDER -- requirements
Module: cmd_frame_builder

---
 rtl/cmd_frame_pkg.sv | 59 +++++
 rtl/cmd_frame_builder_crc.sv | 32 +++
 rtl/cmd_frame_builder.sv | 136 +++++++++++++
 tb/tb_cmd_frame_builder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the command frame builder: frame geometry,
// preamble constants, field bit offsets, FSM state encoding and the
// frame assembly helper used by the top level.
package cmd_frame_pkg;

   localparam int FRAME_LEN = 58;
   localparam int ENTRY_W   = 12;
   localparam int CRC_W     = 16;

   localparam int PRE1_W = 23;
   localparam int PRE2_W = 6;
   localparam logic [PRE1_W-1:0] PRE1 = 23'h00E2E9;
   localparam logic [PRE2_W-1:0] PRE2 = 6'h10;

   // Frame bit positions
   localparam int PRE1_LSB   = 35;
   localparam int DIR_N_BIT  = 34;
   localparam int DIR_BIT    = 33;
   localparam int PRE2_LSB   = 27;
   localparam int SECTOR_MSB = 26;
   localparam int GAIN_MSB   = 19;
   localparam int CRC_LSB    = 0;

   // Memory entry field positions
   localparam int ENTRY_DIR_BIT    = 11;
   localparam int ENTRY_SECTOR_LSB = 4;
   localparam int ENTRY_SECTOR_W   = 7;
   localparam int ENTRY_GAIN_LSB   = 0;
   localparam int ENTRY_GAIN_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CRC  = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // Sector and gain are sent LSB-first, so both fields are bit-reversed
   // when placed into the frame.
   function automatic logic [FRAME_LEN-1:0] build_frame(
      input logic [ENTRY_W-1:0] entry,
      input logic [CRC_W-1:0]   crc
   );
      logic [FRAME_LEN-1:0] f;
      f = '0;
      f[PRE1_LSB +: PRE1_W] = PRE1;
      f[DIR_N_BIT]          = ~entry[ENTRY_DIR_BIT];
      f[DIR_BIT]            = entry[ENTRY_DIR_BIT];
      f[PRE2_LSB +: PRE2_W] = PRE2;
      for (int k = 0; k < ENTRY_SECTOR_W; k++) begin
         f[SECTOR_MSB - k] = entry[ENTRY_SECTOR_LSB + k];
      end
      for (int k = 0; k < ENTRY_GAIN_W; k++) begin
         f[GAIN_MSB - k] = entry[ENTRY_GAIN_LSB + k];
      end
      f[CRC_LSB +: CRC_W] = crc;
      return f;
   endfunction

endpackage

// File: rtl/cmd_frame_builder_crc.sv
// Bit-serial CRC-16 engine: load to CRC_INIT, then absorb one message bit
// per shift, MSB-first. Polynomial has the x^16 term implicit.
module crc16_serial #(
   parameter logic [15:0] CRC_POLY = 16'h1021,
   parameter logic [15:0] CRC_INIT = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic        shift,
   input  logic        bit_in,
   output logic [15:0] crc_value
);

   logic [15:0] crc_q;
   logic        fb;

   assign fb        = crc_q[15] ^ bit_in;
   assign crc_value = crc_q;

   // CRC register: load wins over shift so a new frame always starts clean
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= CRC_INIT;
      end else if (load) begin
         crc_q <= CRC_INIT;
      end else if (shift) begin
         crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
      end
   end

endmodule

// File: rtl/cmd_frame_builder.sv
// Command frame builder: accepts a 12-bit memory entry, runs a 12-cycle
// bit-serial CRC over it and presents a 58-bit command frame until the
// downstream Manchester stage takes it.
// Optional feature macro: CMD_FRAME_CNT_EN enables the delivered-frame
// counter on frame_cnt; without it frame_cnt is tied to zero.
module cmd_frame_builder
   import cmd_frame_pkg::*;
#(
   parameter logic [15:0] CRC_POLY = 16'h1021,
   parameter logic [15:0] CRC_INIT = 16'h0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [ENTRY_W-1:0]   in_entry,
   output logic                 in_ready,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [FRAME_LEN-1:0] frame_data,
   output logic                 busy,
   output logic [15:0]          frame_cnt
);

   state_t             state_q, state_d;
   logic [ENTRY_W-1:0] entry_q;
   logic [3:0]         bit_cnt_q;
   logic [3:0]         bit_idx;
   logic               accept;
   logic               crc_shift;
   logic               crc_bit;
   logic               deliver;
   logic [CRC_W-1:0]   crc_value;

   // Entry bits are fed MSB first: bit 11 on the first CRC cycle, bit 0 last
   assign bit_idx = 4'd11 - bit_cnt_q;
   assign crc_bit = entry_q[bit_idx];

   // A flush on the handshake cycle drops the frame, so it is not a delivery
   assign deliver = out_valid & out_ready & ~flush;

   crc16_serial #(
      .CRC_POLY (CRC_POLY),
      .CRC_INIT (CRC_INIT)
   ) u_crc (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (accept),
      .shift     (crc_shift),
      .bit_in    (crc_bit),
      .crc_value (crc_value)
   );

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and handshake outputs; in_ready is masked by flush so that a
   // flush in IDLE never coincides with an accepted entry
   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      crc_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            busy     = 1'b0;
            in_ready = ~flush;
            if (in_valid && !flush) begin
               accept  = 1'b1;
               state_d = ST_CRC;
            end
         end
         ST_CRC: begin
            crc_shift = 1'b1;
            if (bit_cnt_q == 4'd11) begin
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (flush) begin
         state_d = ST_IDLE;
      end
   end

   // Entry latch and bit counter for the serial CRC pass
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         entry_q   <= '0;
         bit_cnt_q <= 4'd0;
      end else if (accept) begin
         entry_q   <= in_entry;
         bit_cnt_q <= 4'd0;
      end else if (crc_shift) begin
         bit_cnt_q <= bit_cnt_q + 4'd1;
      end
   end

   assign frame_data = out_valid ? build_frame(entry_q, crc_value) : '0;

`ifdef CMD_FRAME_CNT_EN
   logic [15:0] frame_cnt_q;

   // Delivered-frame counter, wraps naturally at 16 bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt_q <= 16'h0000;
      end else if (deliver) begin
         frame_cnt_q <= frame_cnt_q + 16'h0001;
      end
   end

   assign frame_cnt = frame_cnt_q;
`else
   logic unused_deliver;
   assign unused_deliver = deliver;
   assign frame_cnt      = 16'h0000;
`endif

endmodule

// File: tb/tb_cmd_frame_builder.sv
// Scoreboard testbench for cmd_frame_builder: directed cases for the known
// CRC values, hold, flush and reset behaviour, followed by randomized
// entries with random downstream back-pressure.
`timescale 1ns/1ps
module tb_cmd_frame_builder;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic        flush     = 1'b0;
   logic        in_valid  = 1'b0;
   logic [11:0] in_entry  = 12'h000;
   logic        out_ready = 1'b0;
   logic        in_ready;
   logic        out_valid;
   logic        busy;
   logic [57:0] frame_data;
   logic [15:0] frame_cnt;

   typedef struct {
      logic [57:0] frame;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          checks     = 0;
   int          errors     = 0;
   int          cyc        = 0;
   logic [15:0] model_cnt  = 16'h0000;
   bit          rand_ready = 1'b0;

   // monitor state
   logic [57:0] held       = '0;
   bit          in_hold    = 1'b0;
   bit          expect_idle = 1'b0;
   logic [15:0] exp_cnt;
   exp_t        cur;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   cmd_frame_builder dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_entry   (in_entry),
      .in_ready   (in_ready),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .frame_data (frame_data),
      .busy       (busy),
      .frame_cnt  (frame_cnt)
   );

   function automatic logic [15:0] ref_crc(input logic [11:0] e);
      logic [15:0] c;
      c = 16'h0000;
      for (int i = 11; i >= 0; i--) begin
         if (c[15] ^ e[i]) c = (c << 1) ^ 16'h1021;
         else              c = c << 1;
      end
      return c;
   endfunction

   function automatic logic [57:0] ref_frame(input logic [11:0] e);
      return {23'h00E2E9, ~e[11], e[11], 6'h10,
              e[4], e[5], e[6], e[7], e[8], e[9], e[10],
              e[0], e[1], e[2], e[3], ref_crc(e)};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic failNow(input string name);
      checks++;
      errors++;
      $display("[TB] FAIL %s at cycle %0d", name, cyc);
   endtask

   // Offer one entry and hold it until accepted; record the expected frame
   task automatic applyStimulus(input logic [11:0] e);
      bit rdy;
      bit ok;
      int k;
      ok = 1'b0;
      k  = 0;
      @(posedge clk); #1;
      in_entry = e;
      in_valid = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         rdy = in_ready;
         @(posedge clk); #1;
         if (rdy) begin
            ok = 1'b1;
            k  = cyc;
            break;
         end
      end
      in_valid = 1'b0;
      in_entry = 12'($urandom);
      if (ok) sb.push_back('{ref_frame(e), k + 12});
      else    failNow("accept_timeout");
   endtask

   task automatic waitValid(input int max_cycles);
      bit seen;
      seen = 1'b0;
      for (int n = 0; n < max_cycles; n++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) failNow("valid_timeout");
   endtask

   // Scoreboard monitor: pops on the first cycle of each presented frame
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            in_hold     = 1'b0;
            expect_idle = 1'b0;
            model_cnt   = 16'h0000;
            continue;
         end
         if (expect_idle) begin
            checkOutput("idle_after_release", {61'h0, in_ready, busy, out_valid}, 64'h4);
            expect_idle = 1'b0;
         end
`ifdef CMD_FRAME_CNT_EN
         exp_cnt = model_cnt;
`else
         exp_cnt = 16'h0000;
`endif
         checkOutput("frame_cnt", frame_cnt, exp_cnt);
         if (out_valid) begin
            if (!in_hold) begin
               if (sb.size() == 0) begin
                  failNow("unexpected_frame");
               end else begin
                  cur = sb.pop_front();
                  checkOutput("frame_data", frame_data, cur.frame);
                  checkOutput("latency", cyc, cur.due);
               end
               held    = frame_data;
               in_hold = 1'b1;
            end else begin
               checkOutput("hold_stable", frame_data, held);
            end
            checkOutput("in_ready_in_hold", in_ready, 0);
            if (flush) begin
               in_hold     = 1'b0;
               expect_idle = 1'b1;
            end else if (out_ready) begin
               in_hold     = 1'b0;
               model_cnt   = model_cnt + 16'h0001;
               expect_idle = 1'b1;
            end
         end else begin
            in_hold = 1'b0;
            checkOutput("frame_zero", frame_data, 0);
            if (flush) expect_idle = 1'b1;
         end
      end
   end

   // Random back-pressure for the randomized phase
   initial begin
      forever begin
         @(posedge clk); #1;
         if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   // Directed scenarios followed by randomized traffic
   initial begin
      #1;
      checkOutput("reset_ctl", {61'h0, in_ready, out_valid, busy}, 64'h4);
      checkOutput("reset_frame", frame_data, 0);
      checkOutput("reset_cnt", frame_cnt, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // known CRC values with immediate acceptance downstream
      out_ready = 1'b1;
      applyStimulus(12'h001);
      waitValid(40);
      checkOutput("crc_001", frame_data[15:0], 16'h1021);
      checkOutput("dir_001", frame_data[34:33], 2'b10);
      checkOutput("pre1_001", frame_data[57:35], 23'h00E2E9);
      checkOutput("pre2_001", frame_data[32:27], 6'h10);
      checkOutput("sector_001", frame_data[26:20], 7'h00);
      checkOutput("gain_001", frame_data[19:16], 4'b1000);

      applyStimulus(12'h002);
      waitValid(40);
      checkOutput("crc_002", frame_data[15:0], 16'h2042);

      applyStimulus(12'h000);
      waitValid(40);
      checkOutput("crc_000", frame_data[15:0], 16'h0000);
      checkOutput("dir_000", frame_data[34:33], 2'b10);

      // long hold under back-pressure
      @(posedge clk); #1 out_ready = 1'b0;
      applyStimulus(12'h810);
      waitValid(40);
      checkOutput("dir_810", frame_data[34:33], 2'b01);
      checkOutput("sector0_810", frame_data[26], 1'b1);
      repeat (20) @(negedge clk);
      checkOutput("held_valid", out_valid, 1'b1);
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      repeat (3) @(negedge clk);

      // flush during the CRC pass
      out_ready = 1'b1;
      applyStimulus(12'($urandom));
      repeat (4) @(posedge clk);
      #1 flush = 1'b1;
      void'(sb.pop_back());
      @(posedge clk); #1 flush = 1'b0;
      repeat (16) @(negedge clk);

      // flush together with the handshake in HOLD
      @(posedge clk); #1 out_ready = 1'b0;
      applyStimulus(12'($urandom));
      waitValid(40);
      @(posedge clk); #1;
      flush     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (16) @(negedge clk);

      // asynchronous reset mid-frame
      out_ready = 1'b1;
      applyStimulus(12'($urandom));
      repeat (6) @(posedge clk);
      #1 rst_n = 1'b0;
      sb.delete();
      #1;
      checkOutput("midreset_ctl", {61'h0, in_ready, out_valid, busy}, 64'h4);
      checkOutput("midreset_frame", frame_data, 0);
      checkOutput("midreset_cnt", frame_cnt, 0);
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b1;
      applyStimulus(12'hA5C);
      waitValid(40);

      // randomized traffic with random back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) @(posedge clk);
         applyStimulus(12'($urandom));
      end

      begin
         bit drained;
         drained = 1'b0;
         for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid && in_ready) begin
               drained = 1'b1;
               break;
            end
         end
         if (!drained) failNow("drain_timeout");
      end
      rand_ready = 1'b0;
      out_ready  = 1'b0;
      checkOutput("sb_empty", sb.size(), 0);
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
